pixel_frame_reader: RTL and testbench

- Consumer end of the smoothed-pixel write stream.
- Captures `o_wr_valid/o_wr_addr/o_wr_data` writes from `pixel_smoothing` into an internal 1R1W frame RAM.
- On a start pulse, scans the stored frame out in address order, 0..MAX_ADDR, as a valid/ready pixel stream for display/upscale logic.
- Supplies the read side that the smoothing block's write interface lacks. Handles backpressure without losing or duplicating pixels.

---
 rtl/pixel_pkg.sv | 27 ++
 rtl/pixel_frame_reader_if.sv | 29 ++
 rtl/mu_ram_1r1w.sv | 26 ++
 rtl/pixel_skid_fifo.sv | 59 +++++
 rtl/pixel_frame_reader.sv | 131 +++++++++++++
 tb/tb_pixel_frame_reader.sv | 260 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/pixel_pkg.sv
// Shared types and sizing helpers for the frame reader: pixel/beat types and scan FSM states.
package pixel_pkg;

  function automatic int addr_w(input int max_addr);
    return $clog2(max_addr + 1);
  endfunction

  localparam int DEF_MAX_ADDR = 63;
  localparam int DEF_DATAW    = 8;
  localparam int DEF_ADDRW    = addr_w(DEF_MAX_ADDR);

  typedef logic [DEF_DATAW-1:0] pixel_t;

  typedef struct packed {
    logic [DEF_ADDRW-1:0] addr;
    pixel_t               data;
    logic                 last;
  } out_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/pixel_frame_reader_if.sv
// Bundle of the write-capture, scan-control and output-stream signals of the frame reader.
interface pixel_frame_reader_if #(
  parameter int MAX_ADDR = 63,
  parameter int DATAW    = 8
);
  localparam int ADDRW = pixel_pkg::addr_w(MAX_ADDR);

  logic             i_wr_valid;
  logic [ADDRW-1:0] i_wr_addr;
  logic [DATAW-1:0] i_wr_data;
  logic             i_start;
  logic             i_ready;
  logic             o_valid;
  logic [ADDRW-1:0] o_addr;
  logic [DATAW-1:0] o_data;
  logic             o_last;
  logic             o_busy;
  logic             o_frame_done;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_start, i_ready,
    input  o_valid, o_addr, o_data, o_last, o_busy, o_frame_done
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_start, i_ready,
    output o_valid, o_addr, o_data, o_last, o_busy, o_frame_done
  );
endinterface

// File: rtl/mu_ram_1r1w.sv
// Simple dual-port frame RAM: one write port, one registered read port, read-first on collision.
module mu_ram_1r1w #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/pixel_skid_fifo.sv
// Two-entry output buffer with registered head; the writer must respect the reported level.
module pixel_skid_fifo #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);
  logic [W-1:0] head_reg;
  logic [W-1:0] skid_reg;
  logic [1:0]   count_reg;
  logic         push;
  logic         pop;

  assign push      = in_valid && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head_reg;
  assign level     = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      skid_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_reg <= in_data;
          end else begin
            skid_reg <= in_data;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= skid_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Level is unchanged; the head advances and the new beat lands behind it.
          if (count_reg == 2'd1) begin
            head_reg <= in_data;
          end else begin
            head_reg <= skid_reg;
            skid_reg <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: rtl/pixel_frame_reader.sv
// Captures smoothed-pixel writes into a frame RAM and, on request, streams the frame out in
// address order over valid/ready without dropping or repeating pixels.
module pixel_frame_reader #(
  parameter int MAX_ADDR = 63,
  parameter int DATAW    = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  pixel_frame_reader_if.slave bus
);
  import pixel_pkg::*;

  localparam int ADDRW = addr_w(MAX_ADDR);
  localparam int BEATW = 1 + ADDRW + DATAW;
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MAX_ADDR);

  scan_state_t      state_reg;
  logic [ADDRW-1:0] rd_ptr_reg;
  logic [ADDRW-1:0] rd_addr_reg;
  logic             rd_vld_reg;
  logic             rd_last_reg;
  logic             busy_reg;
  logic             frame_done_reg;

  logic [DATAW-1:0] ram_rdata;
  logic             wr_en;
  logic             issue;
  logic             pop;
  logic             ptr_at_max;
  logic [1:0]       fifo_level;
  logic             fifo_valid;
  logic [BEATW-1:0] fifo_in;
  logic [BEATW-1:0] fifo_out;
  logic [2:0]       occ;

  // Out-of-range writes can only exist when the frame does not fill the address space.
  generate
    if ((MAX_ADDR + 1) == (1 << ADDRW)) begin : g_wr_full
      assign wr_en = bus.i_wr_valid;
    end else begin : g_wr_part
      assign wr_en = bus.i_wr_valid && (bus.i_wr_addr <= LAST_ADDR);
    end
  endgenerate

  mu_ram_1r1w #(
    .DEPTH (MAX_ADDR + 1),
    .AW    (ADDRW),
    .DW    (DATAW)
  ) u_ram (
    .clk   (i_clk),
    .we    (wr_en),
    .waddr (bus.i_wr_addr),
    .wdata (bus.i_wr_data),
    .re    (issue),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Occupancy counts the slot freed by this cycle's pop, so a steady stream has no bubbles.
  assign ptr_at_max = (rd_ptr_reg == LAST_ADDR);
  assign pop        = fifo_valid && bus.i_ready;
  assign occ        = 3'(fifo_level) + 3'(rd_vld_reg) - 3'(pop);
  assign issue      = (state_reg == READ) && (occ < 3'd2);
  assign fifo_in    = {rd_last_reg, rd_addr_reg, ram_rdata};

  pixel_skid_fifo #(
    .W (BEATW)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .in_valid  (rd_vld_reg),
    .in_data   (fifo_in),
    .out_valid (fifo_valid),
    .out_ready (bus.i_ready),
    .out_data  (fifo_out),
    .level     (fifo_level)
  );

  assign bus.o_valid                          = fifo_valid;
  assign {bus.o_last, bus.o_addr, bus.o_data} = fifo_out;
  assign bus.o_busy                           = busy_reg;
  assign bus.o_frame_done                     = frame_done_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      rd_ptr_reg     <= '0;
      rd_addr_reg    <= '0;
      rd_vld_reg     <= 1'b0;
      rd_last_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      rd_vld_reg     <= issue;
      frame_done_reg <= 1'b0;
      if (issue) begin
        rd_addr_reg <= rd_ptr_reg;
        rd_last_reg <= ptr_at_max;
      end
      case (state_reg)
        // DONE accepts a start too, so frames can run back to back.
        IDLE, DONE: begin
          if (bus.i_start) begin
            state_reg  <= READ;
            rd_ptr_reg <= '0;
            busy_reg   <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        READ: begin
          if (issue) begin
            if (ptr_at_max) begin
              state_reg <= DRAIN;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + ADDRW'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && fifo_out[BEATW-1]) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_frame_reader.sv
// Scoreboard bench: each scan start queues the expected frame from a memory model; a monitor
// pops and compares every accepted beat and checks beats held under backpressure stay stable.
module tb_pixel_frame_reader;
  import pixel_pkg::*;

  localparam int MAX_ADDR = 63;
  localparam int NPIX     = MAX_ADDR + 1;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  pixel_t    mem_model [NPIX];
  out_beat_t exp_q [$];
  out_beat_t held;
  out_beat_t got;
  out_beat_t want;
  logic      hold_valid = 1'b0;

  always #5 i_clk = ~i_clk;

  pixel_frame_reader_if #(.MAX_ADDR(MAX_ADDR), .DATAW(8)) bus ();

  pixel_frame_reader #(.MAX_ADDR(MAX_ADDR), .DATAW(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, midway between input drive and the next transfer edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_valid = 1'b0;
    end else begin
      got.addr = bus.o_addr;
      got.data = bus.o_data;
      got.last = bus.o_last;
      if (bus.o_frame_done) done_cnt++;
      if (hold_valid) check("hold_stable", 32'({bus.o_valid, got}), 32'({1'b1, held}));
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=addr %0d required=no beat", got.addr);
        end else begin
          want = exp_q.pop_front();
          check("beat_addr", 32'(got.addr), 32'(want.addr));
          check("beat_data", 32'(got.data), 32'(want.data));
          check("beat_last", 32'(got.last), 32'(want.last));
          $display("beat addr=%0d data=%02h last=%0b", got.addr, got.data, got.last);
        end
      end
      hold_valid = bus.o_valid && !bus.i_ready;
      held       = got;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic write_frame(input bit ramp);
    pixel_t d;
    for (int a = 0; a < NPIX; a++) begin
      d = ramp ? 8'(a) : 8'($urandom);
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = 6'(a);
      bus.i_wr_data  = d;
      mem_model[a]   = d;
      cyc(1);
    end
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic push_frame();
    out_beat_t b;
    for (int a = 0; a < NPIX; a++) begin
      b.addr = 6'(a);
      b.data = mem_model[a];
      b.last = (a == MAX_ADDR);
      exp_q.push_back(b);
    end
  endtask

  // Returns one ns after the edge that samples the start (E0).
  task automatic start_scan();
    bus.i_start = 1'b1;
    push_frame();
    cyc(1);
    bus.i_start = 1'b0;
    check("busy_after_start", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic check_latency();
    check("lat_e0_valid", 32'(bus.o_valid), 32'd0);
    cyc(1);
    check("lat_e1_valid", 32'(bus.o_valid), 32'd0);
    cyc(1);
    check("lat_e2_valid", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.o_frame_done && n < 3000) begin
      cyc(1);
      n++;
    end
    check(name, 32'(bus.o_frame_done), 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 32'({bus.o_valid, bus.o_addr, bus.o_data, bus.o_last, bus.o_busy, bus.o_frame_done}), 32'd0);
  endtask

  initial begin : main
    int d0;
    int n;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_start    = 1'b0;
    bus.i_ready    = 1'b0;
    void'($urandom(12));

    cyc(2);
    check("reset_valid", 32'(bus.o_valid), 32'd0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_done", 32'(bus.o_frame_done), 32'd0);
    check_outputs_zero("reset_outputs");
    i_rst_n = 1'b1;
    cyc(1);

    // Ramp frame, ready held high: 64 consecutive valid cycles then a single done pulse.
    write_frame(1'b1);
    bus.i_ready = 1'b1;
    d0 = done_cnt;
    start_scan();
    check_latency();
    for (int i = 0; i < NPIX; i++) begin
      check("ramp_valid_run", 32'(bus.o_valid), 32'd1);
      cyc(1);
    end
    check("ramp_valid_end", 32'(bus.o_valid), 32'd0);
    check("ramp_done_pulse", 32'(bus.o_frame_done), 32'd1);
    check("ramp_busy_end", 32'(bus.o_busy), 32'd0);
    cyc(1);
    check("ramp_done_once", 32'(bus.o_frame_done), 32'd0);
    check("ramp_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("ramp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random frame with random backpressure.
    write_frame(1'b0);
    d0 = done_cnt;
    start_scan();
    n = 0;
    while (!bus.o_frame_done && n < 3000) begin
      bus.i_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    check("rand_done", 32'(bus.o_frame_done), 32'd1);
    bus.i_ready = 1'b1;
    cyc(1);
    check("rand_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Long stall right after start: pixel 0 must wait at the output.
    bus.i_ready = 1'b0;
    start_scan();
    cyc(20);
    check("stall_valid", 32'(bus.o_valid), 32'd1);
    check("stall_addr0", 32'(bus.o_addr), 32'd0);
    bus.i_ready = 1'b1;
    wait_done("stall_done");
    cyc(1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Write to addr 10 in the cycle its read issues, plus an ignored mid-scan start.
    d0 = done_cnt;
    start_scan();
    cyc(10);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 6'd10;
    bus.i_wr_data  = 8'hA5;
    bus.i_start    = 1'b1;
    cyc(1);
    bus.i_wr_valid = 1'b0;
    bus.i_start    = 1'b0;
    mem_model[10]  = 8'hA5;
    wait_done("coll_done");
    cyc(3);
    check("restart_ignored_valid", 32'(bus.o_valid), 32'd0);
    check("restart_ignored_busy", 32'(bus.o_busy), 32'd0);
    check("restart_ignored_count", 32'(done_cnt), 32'(d0 + 1));
    start_scan();
    wait_done("coll_rescan_done");
    cyc(1);
    check("coll_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while pixel 30 is presented.
    start_scan();
    n = 0;
    while (!(bus.o_valid && bus.o_addr == 6'd30) && n < 200) begin
      cyc(1);
      n++;
    end
    check("reach_pixel30", 32'(bus.o_addr), 32'd30);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_outputs_zero("midscan_reset_outputs");
    exp_q.delete();
    d0 = done_cnt;
    cyc(2);
    i_rst_n = 1'b1;
    cyc(2);
    check("midscan_no_done", 32'(done_cnt), 32'(d0));
    check("midscan_idle_valid", 32'(bus.o_valid), 32'd0);
    start_scan();
    check_latency();
    wait_done("after_reset_done");
    cyc(1);
    check("after_reset_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames: second start in the done cycle.
    d0 = done_cnt;
    start_scan();
    wait_done("b2b_first_done");
    start_scan();
    check_latency();
    wait_done("b2b_second_done");
    cyc(1);
    check("b2b_done_count", 32'(done_cnt), 32'(d0 + 2));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
